// File: rtl/feature_stream_tx2.sv
// Frame buffer and paced replay from the layer-1 pooling output into controlprocedure2.
// It stores one 4-channel feature map and then sends it again, one sample per flag pulse.
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   wr_en, wr_d1..wr_d4 write strobe and one 4-channel signed sample
//   start               begins the send phase (only honoured in IDLE)
//   out1..out4, flagout sample to the receiver and its one-cycle strobe
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   level, wr_err       samples buffered / sticky dropped-write flag
module feature_stream_tx2 #(
  parameter int unsigned DEPTH = 500,
  parameter int unsigned GAP   = 4,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_d1,
  input  logic [7:0]    wr_d2,
  input  logic [7:0]    wr_d3,
  input  logic [7:0]    wr_d4,
  input  logic          start,
  output logic [7:0]    out1,
  output logic [7:0]    out2,
  output logic [7:0]    out3,
  output logic [7:0]    out4,
  output logic          flagout,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] level,
  output logic          wr_err
);

  // The GAP state counts 0 .. GAP-2.
  localparam int unsigned GW = $clog2(GAP);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d, wp_upd;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [31:0]     out_q, out_d;
  logic            flag_q, flag_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            mem_we;

  // Sample store, {ch4, ch3, ch2, ch1} per word; contents are not reset.
  logic [31:0]     mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) mem[wp_q] <= {wr_d4, wr_d3, wr_d2, wr_d1};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      gcnt_q  <= '0;
      out_q   <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      gcnt_q  <= gcnt_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    gcnt_d  = gcnt_q;
    out_d   = out_q;
    flag_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    mem_we  = 1'b0;
    wp_upd  = wp_q;

    unique case (state_q)
      ST_IDLE: begin
        out_d = '0;
        if (start) err_d = 1'b0;
        // The write is taken first, so a same-cycle start sends a frame that includes it.
        if (wr_en) begin
          if (wp_q < AW'(DEPTH)) begin
            mem_we = 1'b1;
            wp_upd = wp_q + AW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        wp_d = wp_upd;
        if (start) begin
          rp_d    = '0;
          state_d = (wp_upd != '0) ? ST_SEND : ST_FIN;
        end
      end
      ST_SEND: begin
        out_d   = mem[rp_q];
        flag_d  = 1'b1;
        rp_d    = rp_q + AW'(1);
        gcnt_d  = '0;
        if (wr_en) err_d = 1'b1;
        state_d = ((rp_q + AW'(1)) == wp_q) ? ST_FIN : ST_GAP;
      end
      ST_GAP: begin
        if (wr_en) err_d = 1'b1;
        if (gcnt_q == GW'(GAP - 2)) state_d = ST_SEND;
        else                        gcnt_d  = gcnt_q + GW'(1);
      end
      ST_FIN: begin
        done_d  = 1'b1;
        wp_d    = '0;
        rp_d    = '0;
        out_d   = '0;
        if (wr_en) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign out1    = out_q[7:0];
  assign out2    = out_q[15:8];
  assign out3    = out_q[23:16];
  assign out4    = out_q[31:24];
  assign flagout = flag_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign level   = wp_q;
  assign wr_err  = err_q;

endmodule

// File: tb/tb_feature_stream_tx2.sv
// Bench for feature_stream_tx2: two instances (GAP=4 and GAP=2) share all inputs.
// Accepted writes are queued as expected samples; a negedge monitor pops one per flag
// and checks data, flag spacing, first-flag latency and done timing.
module tb_feature_stream_tx2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, start;
  logic [7:0] wr_d1, wr_d2, wr_d3, wr_d4;

  logic [7:0] o1 [2];
  logic [7:0] o2 [2];
  logic [7:0] o3 [2];
  logic [7:0] o4 [2];
  logic       flg [2];
  logic       bsy [2];
  logic       dn [2];
  logic       err [2];
  logic [8:0] lvl [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int model_wp = 0;
  int start_cyc [2] = '{0, 0};
  int last_cyc  [2] = '{0, 0};
  int ndone     [2] = '{0, 0};
  int nflag     [2] = '{0, 0};
  int busy_cnt  [2] = '{0, 0};
  bit first     [2] = '{1'b1, 1'b1};
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  always #5 clk = ~clk;

  feature_stream_tx2 #(.DEPTH(500), .GAP(4), .AW(9)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_d1(wr_d1), .wr_d2(wr_d2), .wr_d3(wr_d3),
    .wr_d4(wr_d4), .start(start), .out1(o1[0]), .out2(o2[0]), .out3(o3[0]), .out4(o4[0]),
    .flagout(flg[0]), .busy(bsy[0]), .done(dn[0]), .level(lvl[0]), .wr_err(err[0]));

  feature_stream_tx2 #(.DEPTH(500), .GAP(2), .AW(9)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_d1(wr_d1), .wr_d2(wr_d2), .wr_d3(wr_d3),
    .wr_d4(wr_d4), .start(start), .out1(o1[1]), .out2(o2[1]), .out3(o3[1]), .out4(o4[1]),
    .flagout(flg[1]), .busy(bsy[1]), .done(dn[1]), .level(lvl[1]), .wr_err(err[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    logic [31:0] got, expv;
    int gp;
    cyc++;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        gp = (d == 0) ? 4 : 2;
        if (bsy[d]) busy_cnt[d]++;
        if (flg[d]) begin
          nflag[d]++;
          got = {o4[d], o3[d], o2[d], o1[d]};
          expv = 'x;
          if (d == 0) begin if (q0.size() > 0) expv = q0.pop_front(); end
          else        begin if (q1.size() > 0) expv = q1.pop_front(); end
          check($sformatf("dut%0d_data", d), got, expv);
          if (first[d]) check($sformatf("dut%0d_first_flag_lat", d), cyc - start_cyc[d], 2);
          else          check($sformatf("dut%0d_flag_spacing", d), cyc - last_cyc[d], gp);
          first[d]    = 1'b0;
          last_cyc[d] = cyc;
        end
        if (dn[d]) begin
          ndone[d]++;
          check($sformatf("dut%0d_done_left", d), (d == 0) ? q0.size() : q1.size(), 0);
          if (first[d]) check($sformatf("dut%0d_empty_done_lat", d), cyc - start_cyc[d], 2);
          else          check($sformatf("dut%0d_done_after_flag", d), cyc - last_cyc[d], 1);
          first[d] = 1'b1;
        end
        if (start && !bsy[d]) begin
          start_cyc[d] = cyc;
          first[d]     = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write in IDLE; the model queues it only if the buffer has room.
  task automatic put(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [7:0] e);
    wr_en = 1'b1; wr_d1 = a; wr_d2 = b; wr_d3 = c; wr_d4 = e;
    if (model_wp < 500) begin
      q0.push_back({e, c, b, a});
      q1.push_back({e, c, b, a});
      model_wp++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    model_wp = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int t1, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ndone[0] >= t0 && ndone[1] >= t1) break;
      @(negedge clk);
    end
    check("done_count0", ndone[0], t0);
    check("done_count1", ndone[1], t1);
  endtask

  task automatic chk_both(input string tag, input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] exp);
    check({tag, "_0"}, v0, exp);
    check({tag, "_1"}, v1, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int nd0, nd1;
    rst = 1'b0; wr_en = 1'b0; start = 1'b0;
    wr_d1 = '0; wr_d2 = '0; wr_d3 = '0; wr_d4 = '0;
    repeat (3) @(negedge clk);
    // Reset state
    chk_both("rst_out", {o4[0], o3[0], o2[0], o1[0]}, {o4[1], o3[1], o2[1], o1[1]}, 0);
    chk_both("rst_flag", flg[0], flg[1], 0);
    chk_both("rst_busy", bsy[0], bsy[1], 0);
    chk_both("rst_done", dn[0], dn[1], 0);
    chk_both("rst_level", lvl[0], lvl[1], 0);
    chk_both("rst_err", err[0], err[1], 0);
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-frame drops everything at once, no done afterwards
    for (int k = 0; k < 8; k++) put(8'(k + 1), 8'(k + 20), 8'(k + 40), 8'(k + 60));
    go();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (flg[0] && nflag[0] >= 2) break;
    end
    check("pre_rst_flag", flg[0], 1);
    #1 rst = 1'b0;
    #1;
    chk_both("async_flag", flg[0], flg[1], 0);
    chk_both("async_busy", bsy[0], bsy[1], 0);
    chk_both("async_level", lvl[0], lvl[1], 0);
    q0.delete(); q1.delete(); model_wp = 0;
    first[0] = 1'b1; first[1] = 1'b1;
    nd0 = ndone[0]; nd1 = ndone[1];
    tick();
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk_both("no_done_after_rst", ndone[0] - nd0, ndone[1] - nd1, 0);
    tick();

    // Full 500-sample frame
    for (int k = 0; k < 500; k++) begin
      v = 8'(k % 128);
      put(v, -v, v ^ 8'd1, 8'd0);
    end
    chk_both("full_level", lvl[0], lvl[1], 500);
    nflag[0] = 0; nflag[1] = 0;
    go();
    wait_done(ndone[0] + 1, ndone[1] + 1, 3000);
    chk_both("full_nflag", nflag[0], nflag[1], 500);
    chk_both("full_level_after", lvl[0], lvl[1], 0);
    tick();

    // Overfill: 501 writes, start clears the error, frame holds 500
    for (int k = 0; k < 501; k++) put(8'(k * 3), 8'(k * 5), 8'(k + 7), 8'(k ^ 255));
    chk_both("ovf_level", lvl[0], lvl[1], 500);
    chk_both("ovf_err", err[0], err[1], 1);
    nflag[0] = 0; nflag[1] = 0;
    go();
    chk_both("ovf_err_cleared", err[0], err[1], 0);
    wait_done(ndone[0] + 1, ndone[1] + 1, 3000);
    chk_both("ovf_nflag", nflag[0], nflag[1], 500);
    tick();

    // Empty frame: done only, busy for a single cycle
    nflag[0] = 0; nflag[1] = 0;
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    go();
    wait_done(ndone[0] + 1, ndone[1] + 1, 20);
    repeat (3) @(negedge clk);
    chk_both("empty_nflag", nflag[0], nflag[1], 0);
    chk_both("empty_busy_cycles", busy_cnt[0], busy_cnt[1], 1);
    tick();

    // Write and start while sending are ignored, write flags an error
    for (int k = 0; k < 20; k++) put(8'(k * 7), 8'(100 - k), 8'(k), 8'(k << 2));
    nflag[0] = 0; nflag[1] = 0;
    go();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nflag[0] >= 2) break;
    end
    tick();
    wr_en = 1'b1; start = 1'b1; wr_d1 = 8'h55; wr_d2 = 8'h55; wr_d3 = 8'h55; wr_d4 = 8'h55;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk_both("busy_wr_err", err[0], err[1], 1);
    chk_both("busy_level", lvl[0], lvl[1], 20);
    wait_done(ndone[0] + 1, ndone[1] + 1, 200);
    chk_both("busy_nflag", nflag[0], nflag[1], 20);
    tick();

    // Start in the same cycle as the third write
    nflag[0] = 0; nflag[1] = 0;
    put(8'h81, 8'h7f, 8'h01, 8'hfe);
    put(8'h10, 8'hf0, 8'h11, 8'h00);
    start = 1'b1;
    put(8'hc3, 8'h3d, 8'hc2, 8'h00);
    start = 1'b0;
    model_wp = 0;
    chk_both("same_cyc_err_cleared", err[0], err[1], 0);
    wait_done(ndone[0] + 1, ndone[1] + 1, 100);
    chk_both("same_cyc_nflag", nflag[0], nflag[1], 3);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
